cabac_bitstream_buffer: RTL and testbench

- Sits directly downstream of the bitstream file reader and directly upstream of the arithmetic decoding engine.
- Pulls bitstream words from the reader on demand and holds them in an MSB-aligned shift buffer.
- Serves variable-length bit reads (1..9 bits) to the engine for offset initialisation and renormalisation.
- Hides upstream fetch latency: keeps the buffer topped up while at least one word of free space exists.

---
 rtl/cabac_bitstream_buffer.sv | 136 +++++++++++++
 tb/tb_cabac_bitstream_buffer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_bitstream_buffer.sv
// Bitstream shift buffer between the byte reader and the CABAC arithmetic engine.
// Fetches words on demand into an MSB-aligned buffer and serves 1..MAX_RD bit reads.
module cabac_bitstream_buffer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned BUF_W  = 32,
  parameter int unsigned MAX_RD = 9
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fetch_req,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_eof,
  input  logic              rd_req,
  input  logic [3:0]        rd_nbits,
  output logic [MAX_RD-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_underflow,
  output logic [5:0]        bits_avail
);

  localparam int unsigned     CntW     = $clog2(BUF_W + 1);
  // Fetch only while a whole word still fits, so the fill count can never exceed BUF_W.
  localparam logic [CntW-1:0] FetchThr = CntW'(BUF_W - WORD_W);
  localparam logic [CntW-1:0] WordCnt  = CntW'(WORD_W);
  localparam logic [CntW-1:0] BufCnt   = CntW'(BUF_W);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic [BUF_W-1:0]  sbuf_q, sbuf_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              eof_seen_q, eof_seen_d;
  logic [MAX_RD-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_underflow_q, rd_underflow_d;

  logic              rd_short;
  logic              rd_fire;
  logic              append;
  logic [CntW-1:0]   nbits_ext;
  logic [CntW-1:0]   cnt_post_rd;
  logic [BUF_W-1:0]  buf_post_rd;
  logic [BUF_W-1:0]  word_aligned;
  logic [MAX_RD-1:0] rd_window;
  logic [3:0]        rd_shift;

  // Read decode: a read fires when enough bits exist or EOF forces zero padding.
  always_comb begin
    nbits_ext = CntW'(rd_nbits);
    rd_short  = (count_q < nbits_ext);
    // rd_valid_q blocks evaluation so the engine can retire or replace its request.
    rd_fire   = rd_req && !rd_valid_q && (!rd_short || eof_seen_q);
    rd_window = sbuf_q[BUF_W-1 -: MAX_RD];
    rd_shift  = 4'(MAX_RD) - rd_nbits;
  end

  // Buffer datapath: consume first, then append at the post-consume fill level.
  always_comb begin
    buf_post_rd    = sbuf_q;
    cnt_post_rd    = count_q;
    rd_valid_d     = 1'b0;
    rd_underflow_d = 1'b0;
    rd_data_d      = rd_data_q;
    eof_seen_d     = eof_seen_q;
    if (rd_fire) begin
      // Bits below the fill level are always zero, so a short read pads with zeros.
      buf_post_rd    = sbuf_q << rd_nbits;
      cnt_post_rd    = rd_short ? '0 : (count_q - nbits_ext);
      rd_valid_d     = 1'b1;
      rd_underflow_d = rd_short;
      rd_data_d      = rd_window >> rd_shift;
    end
    append       = (state_q == StWait) && in_valid;
    word_aligned = {in_data, {(BUF_W - WORD_W){1'b0}}} >> cnt_post_rd;
    sbuf_d       = append ? (buf_post_rd | word_aligned) : buf_post_rd;
    count_d      = append ? (cnt_post_rd + WordCnt) : cnt_post_rd;
    if ((state_q == StWait) && !in_valid && in_eof) begin
      eof_seen_d = 1'b1;
    end
  end

  // Fetch FSM next-state: at most one outstanding request to the reader.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!eof_seen_q && (count_q <= FetchThr)) begin
          state_d = StReq;
        end
      end
      StReq:  state_d = StWait;
      StWait: begin
        if (in_valid || in_eof) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Fetch FSM output: request pulse lasts exactly the one REQ cycle.
  always_comb begin
    fetch_req = (state_q == StReq);
  end

  // State registers with synchronous reset; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sbuf_q         <= '0;
      count_q        <= '0;
      eof_seen_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sbuf_q         <= sbuf_d;
      count_q        <= count_d;
      eof_seen_q     <= eof_seen_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_underflow = rd_underflow_q;
  assign bits_avail   = 6'(count_q);

  // The fetch threshold makes overflow unreachable; flag it if it ever happens.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count_q <= BufCnt);

endmodule

// File: tb/tb_cabac_bitstream_buffer.sv
// Directed bench for cabac_bitstream_buffer with a small reader model.
module tb_cabac_bitstream_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_eof;
  logic       rd_req;
  logic [3:0] rd_nbits;
  logic [8:0] rd_data;
  logic       rd_valid;
  logic       rd_underflow;
  logic [5:0] bits_avail;

  int checks = 0;
  int errors = 0;

  // Reader model state
  logic [7:0] rdr_q[$];
  int         rdr_lat   = 1;
  bit         rdr_en    = 1'b0;
  int         rdr_given = 0;
  logic       rdr_valid = 1'b0;
  logic [7:0] rdr_data  = 8'h00;
  // Manually driven word strobe
  logic       man_valid = 1'b0;
  logic [7:0] man_data  = 8'h00;

  assign in_valid = rdr_valid | man_valid;
  assign in_data  = rdr_valid ? rdr_data : man_data;

  cabac_bitstream_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_eof       (in_eof),
    .rd_req       (rd_req),
    .rd_nbits     (rd_nbits),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_underflow (rd_underflow),
    .bits_avail   (bits_avail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_req === 1'b1) begin
      assert (rd_nbits >= 4'd1 && rd_nbits <= 4'd9) else $error("illegal rd_nbits %0d", rd_nbits);
    end
  end

  // Reader: answers a fetch_req after rdr_lat edges with the next queued word.
  initial begin : reader
    logic [7:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (rdr_en && fetch_req === 1'b1 && rdr_q.size() != 0) begin
        w = rdr_q.pop_front();
        repeat (rdr_lat) @(posedge clk);
        #1;
        rdr_data  = w;
        rdr_valid = 1'b1;
        rdr_given++;
        @(posedge clk);
        #1;
        rdr_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rdr_en    = 1'b0;
    rd_req    = 1'b0;
    rd_nbits  = 4'd1;
    man_valid = 1'b0;
    in_eof    = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] n, output logic [8:0] data, output logic uf,
                         output logic [5:0] avail, output bit ok);
    rd_nbits = n;
    rd_req   = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (rd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    data   = rd_data;
    uf     = rd_underflow;
    avail  = bits_avail;
    rd_req = 1'b0;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fetch_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic feed(input logic [7:0] w, output bit ok);
    wait_fetch(ok);
    tick();
    man_data  = w;
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
  endtask

  task automatic test_reset();
    rdr_en    = 1'b0;
    rd_req    = 1'b0;
    rd_nbits  = 4'd1;
    man_valid = 1'b0;
    in_eof    = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    checks++;
    if (bits_avail !== 6'd0) begin
      errors++; $display("FAIL reset_bits_avail: got %0d expected 0", bits_avail);
    end
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++; $display("FAIL reset_fetch_req: got %b expected 0", fetch_req);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_underflow !== 1'b0) begin
      errors++; $display("FAIL reset_rd_flags: got %b%b expected 00", rd_valid, rd_underflow);
    end
    checks++;
    if (rd_data !== 9'h000) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 000", rd_data);
    end
  endtask

  task automatic test_fill();
    int pulses = 0;
    int viol   = 0;
    rdr_q.delete();
    rdr_q.push_back(8'hA5);
    rdr_q.push_back(8'h3C);
    rdr_q.push_back(8'hFF);
    rdr_q.push_back(8'h00);
    rdr_lat   = 1;
    rdr_given = 0;
    rdr_en    = 1'b1;
    rst       = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (fetch_req === 1'b1) begin
        pulses++;
        if (bits_avail > 6'd24) viol++;
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL fill_fetch_pulses: got %0d expected 4", pulses);
    end
    checks++;
    if (bits_avail !== 6'd32) begin
      errors++; $display("FAIL fill_bits_avail: got %0d expected 32", bits_avail);
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL fill_fetch_above_24: got %0d expected 0", viol);
    end
  endtask

  task automatic test_reads();
    logic [8:0] d;
    logic       uf;
    logic [5:0] av;
    bit         ok;
    int         pulses = 0;
    rdr_q.push_back(8'h5A);
    rdr_q.push_back(8'hC3);
    rdr_lat   = 4;
    rdr_given = 0;
    do_read(4'd9, d, uf, av, ok);
    checks++;
    if (!ok || d !== 9'h14A || av !== 6'd23) begin
      errors++; $display("FAIL read9: got ok=%0d data=%h avail=%0d expected ok=1 data=14a avail=23", ok, d, av);
    end
    do_read(4'd7, d, uf, av, ok);
    checks++;
    if (!ok || d !== 9'h03C || av !== 6'd16) begin
      errors++; $display("FAIL read7: got ok=%0d data=%h avail=%0d expected ok=1 data=03c avail=16", ok, d, av);
    end
    do_read(4'd1, d, uf, av, ok);
    checks++;
    if (!ok || d !== 9'h001 || av !== 6'd15 || uf !== 1'b0) begin
      errors++; $display("FAIL read1: got ok=%0d data=%h avail=%0d uf=%b expected ok=1 data=001 avail=15 uf=0", ok, d, av, uf);
    end
    for (int i = 0; i < 40 && bits_avail === 6'd15; i++) tick();
    checks++;
    if (bits_avail !== 6'd23) begin
      errors++; $display("FAIL refill_first: got %0d expected 23", bits_avail);
    end
    for (int i = 0; i < 40 && bits_avail === 6'd23; i++) tick();
    checks++;
    if (bits_avail !== 6'd31) begin
      errors++; $display("FAIL refill_second: got %0d expected 31", bits_avail);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bits_avail !== 6'd31) begin
      errors++; $display("FAIL full_no_fetch: got pulses=%0d avail=%0d expected 0 and 31", pulses, bits_avail);
    end
    do_read(4'd9, d, uf, av, ok);
    checks++;
    if (!ok || d !== 9'h1FC || av !== 6'd22) begin
      errors++; $display("FAIL read_after_refill: got ok=%0d data=%h avail=%0d expected ok=1 data=1fc avail=22", ok, d, av);
    end
  endtask

  task automatic test_stall();
    logic [8:0] d;
    logic       uf;
    logic [5:0] av;
    bit         ok;
    apply_reset();
    rdr_q.delete();
    rdr_q.push_back(8'h80);
    rdr_q.push_back(8'h40);
    rdr_lat   = 3;
    rdr_given = 0;
    rdr_en    = 1'b1;
    do_read(4'd9, d, uf, av, ok);
    checks++;
    if (!ok || d !== 9'h100 || uf !== 1'b0) begin
      errors++; $display("FAIL stall_read: got ok=%0d data=%h uf=%b expected ok=1 data=100 uf=0", ok, d, uf);
    end
    checks++;
    if (rdr_given != 2 || av !== 6'd7) begin
      errors++; $display("FAIL stall_timing: got words=%0d avail=%0d expected 2 and 7", rdr_given, av);
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] d;
    logic       uf;
    logic [5:0] av;
    bit         ok1, ok2, ok3;
    apply_reset();
    feed(8'h12, ok1);
    feed(8'h34, ok2);
    wait_fetch(ok3);
    checks++;
    if (!ok1 || !ok2 || !ok3 || bits_avail !== 6'd16) begin
      errors++; $display("FAIL simul_setup: got fetches=%0d%0d%0d avail=%0d expected 111 and 16", ok1, ok2, ok3, bits_avail);
    end
    tick();
    man_data  = 8'h11;
    man_valid = 1'b1;
    rd_nbits  = 4'd8;
    rd_req    = 1'b1;
    tick();
    man_valid = 1'b0;
    rd_req    = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 9'h012 || bits_avail !== 6'd16) begin
      errors++; $display("FAIL simul_read: got valid=%b data=%h avail=%0d expected 1 012 16", rd_valid, rd_data, bits_avail);
    end
    do_read(4'd8, d, uf, av, ok1);
    checks++;
    if (!ok1 || d !== 9'h034 || av !== 6'd8) begin
      errors++; $display("FAIL simul_next: got ok=%0d data=%h avail=%0d expected ok=1 data=034 avail=8", ok1, d, av);
    end
    do_read(4'd8, d, uf, av, ok1);
    checks++;
    if (!ok1 || d !== 9'h011 || av !== 6'd0) begin
      errors++; $display("FAIL simul_appended: got ok=%0d data=%h avail=%0d expected ok=1 data=011 avail=0", ok1, d, av);
    end
  endtask

  task automatic test_eof();
    logic [8:0] d;
    logic       uf;
    logic [5:0] av;
    bit         ok1, ok2, ok3;
    int         pulses = 0;
    apply_reset();
    feed(8'hF0, ok1);
    wait_fetch(ok2);
    tick();
    in_eof = 1'b1;
    tick();
    do_read(4'd9, d, uf, av, ok3);
    checks++;
    if (!ok1 || !ok2 || !ok3 || d !== 9'h1E0 || uf !== 1'b1 || av !== 6'd0) begin
      errors++; $display("FAIL eof_read: got ok=%0d%0d%0d data=%h uf=%b avail=%0d expected 111 1e0 1 0", ok1, ok2, ok3, d, uf, av);
    end
    tick();
    checks++;
    if (rd_underflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 9'h1E0) begin
      errors++; $display("FAIL eof_after: got uf=%b valid=%b data=%h expected 0 0 1e0", rd_underflow, rd_valid, rd_data);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL eof_no_fetch: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    apply_reset();
    wait_fetch(ok);
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    man_data  = 8'hAA;
    man_valid = 1'b1;
    checks++;
    if (!ok || fetch_req !== 1'b0) begin
      errors++; $display("FAIL rst_wait_idle: got ok=%0d fetch_req=%b expected 1 0", ok, fetch_req);
    end
    tick();
    man_valid = 1'b0;
    checks++;
    if (bits_avail !== 6'd0 || fetch_req !== 1'b1) begin
      errors++; $display("FAIL rst_wait_refetch: got avail=%0d fetch_req=%b expected 0 1", bits_avail, fetch_req);
    end
    tick();
    checks++;
    if (bits_avail !== 6'd0 || fetch_req !== 1'b0) begin
      errors++; $display("FAIL rst_wait_ignored: got avail=%0d fetch_req=%b expected 0 0", bits_avail, fetch_req);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reads();
    test_stall();
    test_simultaneous();
    test_eof();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
